// File: rtl/tcm_dump.sv
// TCM read-back engine: streams a range of 32-bit TCM words out as little-endian
// bytes on a valid/ready byte channel and accumulates an additive checksum.
module tcm_dump #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       sum_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [1:0]        idx_reg, idx_next;
  logic [31:0]       word_reg, word_next;
  logic [31:0]       sum_reg, sum_next;
  logic [7:0]        lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word_reg[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
      word_reg      <= '0;
      sum_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      idx_reg       <= idx_next;
      word_reg      <= word_next;
      sum_reg       <= sum_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    idx_next       = idx_reg;
    word_next      = word_reg;
    sum_next       = sum_reg;

    // Abort freezes every datapath register so the partial checksum survives.
    if (abort_i && state_reg != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            addr_next      = base_i;
            remaining_next = count_i;
            sum_next       = '0;
            state_next     = (count_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: state_next = S_WAIT;
        S_WAIT: begin
          word_next  = mem_data_i;
          sum_next   = sum_reg + mem_data_i;
          idx_next   = '0;
          state_next = S_SEND;
        end
        S_SEND: begin
          if (tx_ready_i) begin
            if (idx_reg != 2'd3) begin
              idx_next = idx_reg + 2'd1;
            end else if (remaining_reg == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_next = S_DONE;
            end else begin
              remaining_next = remaining_reg - {{ADDR_W{1'b0}}, 1'b1};
              addr_next      = addr_reg + 1'b1;
              state_next     = S_READ;
            end
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state; tx_ready_i only steers next state.
  assign busy_o     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done_o     = (state_reg == S_DONE);
  assign sum_o      = sum_reg;
  assign mem_rd_o   = (state_reg == S_READ);
  assign mem_addr_o = addr_reg;
  assign tx_valid_o = (state_reg == S_SEND);
  assign tx_data_o  = lane[idx_reg];

endmodule

// File: tb/tb_tcm_dump.sv
// Directed bench for tcm_dump: a registered-read TCM model plus a monitor that
// logs reads, done pulses and byte transfers for each scenario task to check.
module tb_tcm_dump;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i, tx_ready_i;
  logic [AW-1:0] base_i;
  logic [AW:0]   count_i;
  logic          busy_o, done_o, mem_rd_o, tx_valid_o;
  logic [31:0]   sum_o, mem_data_i;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    tx_data_o;

  logic [31:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    byte_q [$];
  logic [AW-1:0] addr_q [$];
  int            rd_cyc_q [$];
  int            done_cyc_q [$];
  int            first_valid = -1;
  int            start_cyc = -1;
  int            stab_err = 0;
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_data = 8'h00;

  tcm_dump #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .count_i(count_i), .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
  end

  // Cycle k is the cycle that ends at the posedge where cyc == k.
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_rd_o) begin
        rd_cyc_q.push_back(cyc);
        addr_q.push_back(mem_addr_o);
      end
      if (done_o) done_cyc_q.push_back(cyc);
      if (tx_valid_o && tx_ready_i) byte_q.push_back(tx_data_o);
      if (tx_valid_o && first_valid < 0) first_valid = cyc;
      if (start_i && !busy_o && !done_o) start_cyc = cyc;
      if (prev_stall && tx_valid_o && tx_data_o !== prev_data) stab_err++;
    end
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
    cyc = cyc + 1;
  end

  task automatic clear_logs();
    byte_q.delete();
    addr_q.delete();
    rd_cyc_q.delete();
    done_cyc_q.delete();
    first_valid = -1;
    start_cyc   = -1;
    stab_err    = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
    @(negedge clk);
    base_i  = b;
    count_i = c;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL wait_done: no done_o within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b1;
    base_i = '0; count_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, sum_o, mem_rd_o, mem_addr_o, tx_valid_o, tx_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h rd=%b addr=%h valid=%b data=%h, all must be 0",
               busy_o, done_o, sum_o, mem_rd_o, mem_addr_o, tx_valid_o, tx_data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_logs();
    do_start(15'h0000, 16'd2);
    wait_done(40);
    checks++;
    if (byte_q.size() != 8) begin
      errors++; $display("FAIL basic_byte_count: got %0d bytes, want 8", byte_q.size());
    end
    for (int k = 0; k < 8 && k < byte_q.size(); k++) begin
      checks++;
      if (byte_q[k] !== 8'(k + 1)) begin
        errors++; $display("FAIL basic_byte[%0d]: got %h want %h", k, byte_q[k], 8'(k + 1));
      end
    end
    checks++;
    if (rd_cyc_q.size() != 2 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL basic_counts: reads=%0d dones=%0d, want 2 and 1", rd_cyc_q.size(), done_cyc_q.size());
    end else begin
      checks++;
      if (done_cyc_q[0] - rd_cyc_q[0] != 12) begin
        errors++; $display("FAIL basic_done_timing: done %0d cycles after first read, want 12", done_cyc_q[0] - rd_cyc_q[0]);
      end
    end
    checks++;
    if (sum_o !== 32'h0C0A0806) begin
      errors++; $display("FAIL basic_sum: got %h want 0c0a0806", sum_o);
    end
  endtask

  task automatic test_latency();
    clear_logs();
    do_start(15'h0001, 16'd1);
    wait_done(20);
    checks++;
    if (rd_cyc_q.size() != 1 || addr_q.size() != 1) begin
      errors++; $display("FAIL latency_reads: got %0d read cycles, want 1", rd_cyc_q.size());
    end else begin
      checks++;
      if (rd_cyc_q[0] != start_cyc + 1 || addr_q[0] !== 15'h0001) begin
        errors++; $display("FAIL latency_read: rd cycle %0d addr %h, want cycle %0d addr 0001", rd_cyc_q[0], addr_q[0], start_cyc + 1);
      end
    end
    checks++;
    if (first_valid != start_cyc + 3) begin
      errors++; $display("FAIL latency_valid: first tx_valid cycle %0d, want %0d", first_valid, start_cyc + 3);
    end
    checks++;
    if (sum_o !== 32'h08070605) begin
      errors++; $display("FAIL latency_sum: got %h want 08070605", sum_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    pat = 32'hB2D6_7419;
    clear_logs();
    tx_ready_i = 1'b0;
    do_start(15'h0000, 16'd2);
    for (int i = 0; i < 300 && done_cyc_q.size() == 0; i++) begin
      @(negedge clk);
      tx_ready_i = (i >= 5 && i < 15) ? 1'b0 : pat[i % 32];
    end
    tx_ready_i = 1'b1;
    wait_done(20);
    checks++;
    if (byte_q.size() != 8) begin
      errors++; $display("FAIL bp_byte_count: got %0d bytes, want 8", byte_q.size());
    end
    for (int k = 0; k < 8 && k < byte_q.size(); k++) begin
      checks++;
      if (byte_q[k] !== 8'(k + 1)) begin
        errors++; $display("FAIL bp_byte[%0d]: got %h want %h", k, byte_q[k], 8'(k + 1));
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_stable: tx_data changed %0d times while stalled, want 0", stab_err);
    end
    checks++;
    if (sum_o !== 32'h0C0A0806 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL bp_sum_done: sum %h dones %0d, want 0c0a0806 and 1", sum_o, done_cyc_q.size());
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    do_start(15'h7FFF, 16'd3);
    wait_done(60);
    checks++;
    if (addr_q.size() != 3) begin
      errors++; $display("FAIL wrap_reads: got %0d reads, want 3", addr_q.size());
    end else begin
      checks++;
      if (addr_q[0] !== 15'h7FFF || addr_q[1] !== 15'h0000 || addr_q[2] !== 15'h0001) begin
        errors++; $display("FAIL wrap_addr: got %h %h %h want 7fff 0000 0001", addr_q[0], addr_q[1], addr_q[2]);
      end
    end
    checks++;
    if (byte_q.size() != 12 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL wrap_counts: bytes %0d dones %0d, want 12 and 1", byte_q.size(), done_cyc_q.size());
    end else begin
      checks++;
      if (byte_q[0] !== 8'h44 || byte_q[3] !== 8'h11 || byte_q[11] !== 8'h08) begin
        errors++; $display("FAIL wrap_bytes: got %h %h %h want 44 11 08", byte_q[0], byte_q[3], byte_q[11]);
      end
    end
    checks++;
    if (sum_o !== 32'h1D2C3B4A) begin
      errors++; $display("FAIL wrap_sum: got %h want 1d2c3b4a", sum_o);
    end
  endtask

  task automatic test_count_zero();
    clear_logs();
    @(negedge clk);
    base_i = 15'h0003; count_i = 16'd0; start_i = 1'b1;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || sum_o !== 32'h0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b sum=%h want 1 0 00000000", done_o, busy_o, sum_o);
    end
    base_i = 15'h0000; count_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_rd_o !== 1'b0) begin
      errors++; $display("FAIL zero_start_in_done: busy=%b done=%b rd=%b want 0 0 0", busy_o, done_o, mem_rd_o);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cyc_q.size() != 0 || first_valid != -1 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL zero_activity: reads %0d first_valid %0d dones %0d want 0 -1 1",
                         rd_cyc_q.size(), first_valid, done_cyc_q.size());
    end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    do_start(15'h0000, 16'd2);
    repeat (4) @(negedge clk);
    base_i = 15'h0005; count_i = 16'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(40);
    checks++;
    if (addr_q.size() != 2) begin
      errors++; $display("FAIL ignore_reads: got %0d reads, want 2", addr_q.size());
    end else begin
      checks++;
      if (addr_q[0] !== 15'h0000 || addr_q[1] !== 15'h0001) begin
        errors++; $display("FAIL ignore_addr: got %h %h want 0000 0001", addr_q[0], addr_q[1]);
      end
    end
    checks++;
    if (byte_q.size() != 8 || sum_o !== 32'h0C0A0806) begin
      errors++; $display("FAIL ignore_result: bytes %0d sum %h want 8 0c0a0806", byte_q.size(), sum_o);
    end
  endtask

  task automatic test_abort();
    clear_logs();
    tx_ready_i = 1'b1;
    do_start(15'h0000, 16'd2);
    repeat (10) @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h07) begin
      errors++; $display("FAIL abort_pre: valid=%b data=%h want 1 07", tx_valid_o, tx_data_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle: valid=%b busy=%b want 0 0", tx_valid_o, busy_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cyc_q.size() != 0 || sum_o !== 32'h0C0A0806) begin
      errors++; $display("FAIL abort_after: dones %0d sum %h want 0 0c0a0806", done_cyc_q.size(), sum_o);
    end
    clear_logs();
    do_start(15'h0000, 16'd2);
    wait_done(40);
    checks++;
    if (byte_q.size() != 8 || sum_o !== 32'h0C0A0806 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL abort_restart: bytes %0d sum %h dones %0d want 8 0c0a0806 1",
                         byte_q.size(), sum_o, done_cyc_q.size());
    end
  endtask

  task automatic test_rst_mid();
    clear_logs();
    do_start(15'h0005, 16'd2);
    checks++;
    if (mem_rd_o !== 1'b1 || mem_addr_o !== 15'h0005) begin
      errors++; $display("FAIL rst_pre: rd=%b addr=%h want 1 0005", mem_rd_o, mem_addr_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, sum_o, mem_rd_o, mem_addr_o, tx_valid_o, tx_data_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b sum=%h rd=%b addr=%h valid=%b data=%h, all must be 0",
               busy_o, done_o, sum_o, mem_rd_o, mem_addr_o, tx_valid_o, tx_data_o);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (done_cyc_q.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: dones %0d busy %b want 0 0", done_cyc_q.size(), busy_o);
    end
  endtask

  initial begin
    mem[15'h0000] = 32'h04030201;
    mem[15'h0001] = 32'h08070605;
    mem[15'h0005] = 32'hDEADBEEF;
    mem[15'h7FFF] = 32'h11223344;
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_start_ignored();
    test_abort();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
